mac_array_ctrl: RTL and testbench
=================================

// Module: mac_array_ctrl
//
// PURPOSE
//   Sequencer for the MAC processing-element array. Accepts one dot-product job,
//   clears the PE accumulators, then streams k_len operand pairs from the operand
//   buffer into the PEs. It waits for the accumulator register to settle and
//   presents a result-valid handshake to the readout/writeback logic.
//   Sits between the accelerator command interface and the PE array's
//   enable/clear_acc inputs.
//
// PARAMETERS
//   K_W        16  width of k_len, rd_addr and the internal element counter
//   DRAIN_CYC   1  cycles between the last pe_enable and res_valid (>=1; PE acc latency)
//
// PORTS
//   clk        in   1    clock, all logic on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    job request; accepted only in IDLE
//   k_len      in   K_W  reduction length, sampled when start is accepted
//   abort      in   1    synchronous abort of the current job
//   busy       out  1    high in every state except IDLE
//   op_valid   in   1    operand buffer has a_in/b_in pair for rd_addr this cycle
//   op_ready   out  1    controller consumes operand pair (high only in RUN)
//   rd_addr    out  K_W  index of the operand pair being requested
//   pe_clear   out  1    drives PE clear_acc
//   pe_enable  out  1    drives PE enable
//   res_valid  out  1    PE acc_out holds the final result
//   res_ready  in   1    downstream has taken the result
//
// BEHAVIOUR
//   - Reset values: state=IDLE; busy, op_ready, pe_clear, pe_enable and res_valid are 0;
//     rd_addr=0; counters are 0. Asserting rst_n at any point, mid-job included, returns
//     to IDLE immediately. PE accumulators are not guaranteed cleared by this block.
//   - FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE. All outputs are
//     registered-state decodes, except pe_enable, which is state and op_valid.
//   - IDLE: start=1 latches k_reg<=k_len, cnt<=0, next=CLEAR. Start is ignored in any
//     other state.
//   - CLEAR: one cycle with pe_clear=1. If k_reg==0, next=DRAIN (result reads as 0).
//     Otherwise next=RUN.
//   - RUN: op_ready=1, rd_addr=cnt, pe_enable=op_valid.
//     - On op_valid: cnt<=cnt+1. If cnt==k_reg-1, next=DRAIN.
//     - When op_valid=0, the cycle is a stall: no enable and cnt holds.
//   - DRAIN: pe_enable=0 for exactly DRAIN_CYC cycles (dcnt), then DONE.
//   - DONE: res_valid=1, held until res_ready=1. The handshake cycle moves to IDLE,
//     and res_valid drops on the next cycle.
//   - Job length: cnt is K_W bits. The maximum k_len is 2^K_W-1, with no wrap.
//     Total job latency from start accept to res_valid = 1 + k_len + stalls + DRAIN_CYC.
//   - abort=1 in any non-IDLE state:
//     - next=IDLE; pe_enable and op_ready are forced 0 that cycle.
//     - res_valid is never raised for that job.
//     - abort has priority over res_ready and all state transitions. It is ignored in IDLE.
//   - start and abort both high in IDLE: start is accepted (abort ignored).
//   - pe_clear and pe_enable are never high in the same cycle.
//
// CONFIGURATION
//   MAC_CTRL_PERF_EN defined:
//   - Adds output stall_cnt [31:0], counting RUN cycles with op_valid=0.
//   - stall_cnt is cleared to 0 when start is accepted and saturates at 32'hFFFF_FFFF.
//   - Reset value is 0. Its value is held after the job ends.
//   MAC_CTRL_PERF_EN undefined:
//   - The port and counter are absent. All other behaviour is identical.
//
// TESTING
//   1. k_len=4, op_valid tied 1, DRAIN_CYC=1:
//      - pe_clear for 1 cycle, then pe_enable for 4 cycles with rd_addr 0,1,2,3.
//      - res_valid 6 cycles after start accept; a PE fed a=3, b=-2 reads acc_out=-24.
//   2. k_len=3, op_valid low on the 2nd RUN cycle only:
//      - pe_enable goes 1,0,1,1 and rd_addr holds at 1 during the stall.
//      - res_valid arrives 1 cycle later than without the stall; stall_cnt=1 (PERF_EN).
//   3. k_len=0: CLEAR -> DRAIN -> DONE. No pe_enable pulse; res_valid after 2 cycles;
//      acc_out=0.
//   4. Job running, abort at cnt=2 of k_len=8:
//      - Next cycle is IDLE with busy=0 and no res_valid.
//      - A new start with k_len=2 runs normally.
//   5. rst_n pulsed low during RUN: all outputs are 0 asynchronously and the state is IDLE.
//      Start during DONE is ignored; res_valid holds with res_ready=0 for 10 cycles,
//      then clears one cycle after res_ready.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the MAC PE array: clear, stream k_len operand pairs, drain, hand off result.
// Optional MAC_CTRL_PERF_EN adds a saturating stall_cnt output of RUN cycles starved of operands.
module mac_array_ctrl #(
    parameter int K_W       = 16,
    parameter int DRAIN_CYC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           abort,
    output logic           busy,
    input  logic           op_valid,
    output logic           op_ready,
    output logic [K_W-1:0] rd_addr,
    output logic           pe_clear,
    output logic           pe_enable,
    output logic           res_valid,
    input  logic           res_ready
`ifdef MAC_CTRL_PERF_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int D_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYC - 1);

    state_t         state;
    logic [K_W-1:0] k_reg;
    logic [K_W-1:0] cnt;
    logic [D_W-1:0] dcnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k_reg <= '0;
            cnt   <= '0;
            dcnt  <= '0;
        end else if (state != IDLE && abort) begin
            // Abort outranks every transition, including the DONE handshake.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        cnt   <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    dcnt  <= '0;
                    state <= (k_reg == '0) ? DRAIN : RUN;
                end
                RUN: begin
                    if (op_valid) begin
                        cnt <= cnt + K_W'(1);
                        if (cnt == k_reg - K_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcnt == D_LAST) state <= DONE;
                    else                dcnt  <= dcnt + D_W'(1);
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register; only the RUN-phase strobes see op_valid/abort.
    assign busy      = (state != IDLE);
    assign pe_clear  = (state == CLEAR);
    assign op_ready  = (state == RUN) && !abort;
    assign pe_enable = op_ready && op_valid;
    assign res_valid = (state == DONE);
    assign rd_addr   = cnt;

`ifdef MAC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && !abort && !op_valid && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: job-level timing model plus directed scenarios.
// Build with +define+MAC_CTRL_PERF_EN to also check stall_cnt.
module tb_mac_array_ctrl;

    localparam int K_W   = 8;
    localparam int DRAIN = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           abort;
    logic           busy;
    logic           op_valid;
    logic           op_ready;
    logic [K_W-1:0] rd_addr;
    logic           pe_clear;
    logic           pe_enable;
    logic           res_valid;
    logic           res_ready;
`ifdef MAC_CTRL_PERF_EN
    logic [31:0]    stall_cnt;
`endif

    mac_array_ctrl #(.K_W(K_W), .DRAIN_CYC(DRAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .rd_addr   (rd_addr),
        .pe_clear  (pe_clear),
        .pe_enable (pe_enable),
        .res_valid (res_valid),
        .res_ready (res_ready)
`ifdef MAC_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // PE stand-in fed a=3, b=-2 on every enable; deliberately not touched by rst_n.
    int acc = 0;
    always @(posedge clk) begin
        if (pe_clear)       acc <= 0;
        else if (pe_enable) acc <= acc + 3 * (-2);
    end

    // Job-level model: t counts cycles since the accept edge, n operands consumed, s stalls.
    int     m_active = 0, m_t = 0, m_k = 0, m_s = 0, m_n = 0;
    longint m_stall = 0;
    bit     m_run, m_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_n      = 0;
            m_stall  = 0;
        end
        m_run = (m_active != 0) && m_t >= 1 && m_n < m_k;
        m_rv  = (m_active != 0) && m_n == m_k && m_t >= 1 + m_k + m_s + DRAIN;
        check("busy",      busy,      m_active != 0);
        check("pe_clear",  pe_clear,  (m_active != 0) && m_t == 0);
        check("op_ready",  op_ready,  m_run && !abort);
        check("pe_enable", pe_enable, m_run && op_valid && !abort);
        check("rd_addr",   rd_addr,   m_n);
        check("res_valid", res_valid, m_rv);
`ifdef MAC_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (rst_n) begin
            if (m_active == 0) begin
                if (start) begin
                    m_active = 1; m_t = 0; m_k = int'(k_len); m_s = 0; m_n = 0; m_stall = 0;
                end
            end else if (abort) begin
                m_active = 0;
            end else begin
                if (m_run) begin
                    if (op_valid) m_n++;
                    else begin
                        m_s++;
                        if (m_stall != 64'hFFFF_FFFF) m_stall++;
                    end
                end
                if (m_rv && res_ready) m_active = 0;
                m_t++;
            end
        end
    end

    // Per-job trace of RUN cycles: rd_addr nibbles and pe_enable bits, plus clear pulses.
    int run_cycles, clr_cycles;
    int addr_hist, en_bits;
    always @(negedge clk) begin
        if (op_ready) begin
            run_cycles++;
            addr_hist = (addr_hist << 4) | int'(rd_addr[3:0]);
            en_bits   = (en_bits << 1) | int'(pe_enable);
        end
        if (pe_clear) clr_cycles++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trace();
        run_cycles = 0; clr_cycles = 0; addr_hist = 0; en_bits = 0;
    endtask

    // Waits (bounded) for res_valid; starts in CLEAR, mask bit i drops op_valid i cycles in.
    task automatic wait_done(input logic [31:0] mask, input string name, input int exp_lat);
        int lat = 0;
        op_valid = !mask[0];
        while (!res_valid && lat < 2000) begin
            cycle();
            lat++;
            op_valid = (lat < 32) ? !mask[lat] : 1'b1;
        end
        op_valid = 1'b1;
        check(name, lat, exp_lat);
    endtask

    task automatic accept(input int k);
        clear_trace();
        start = 1'b1;
        k_len = K_W'(k);
        cycle();
        start = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        check("res_drop", res_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0;
        op_valid = 1'b1; res_ready = 1'b0;
        repeat (2) cycle();
        check("rst_busy",   busy,      0);
        check("rst_rdaddr", rd_addr,   0);
        check("rst_resv",   res_valid, 0);
        rst_n = 1'b1;
        cycle();

        // Plain k=4 job.
        accept(4);
        wait_done(32'h0, "t1_latency", 6);
        check("t1_acc",   acc,        -24);
        check("t1_addrs", addr_hist,  'h0123);
        check("t1_en",    en_bits,    'hF);
        check("t1_clear", clr_cycles, 1);
        handshake();
        cycle();

        // k=3 with a stall on the second RUN cycle.
        accept(3);
        wait_done(32'h4, "t2_latency", 6);
        check("t2_en",    en_bits,   'b1011);
        check("t2_addrs", addr_hist, 'h0112);
        check("t2_acc",   acc,       -18);
`ifdef MAC_CTRL_PERF_EN
        check("t2_stall", stall_cnt, 1);
`endif
        handshake();

        // Zero-length job.
        accept(0);
        wait_done(32'h0, "t3_latency", 2);
        check("t3_run",   run_cycles, 0);
        check("t3_clear", clr_cycles, 1);
        check("t3_acc",   acc,        0);
        handshake();

        // Abort at cnt=2 of k=8, then start+abort together in IDLE.
        accept(8);
        repeat (3) cycle();
        check("t4_addr", rd_addr, 2);
        abort = 1'b1;
        #1;
        check("t4_en_abort",  pe_enable, 0);
        check("t4_rdy_abort", op_ready,  0);
        cycle();
        abort = 1'b0;
        check("t4_idle", busy, 0);
        repeat (3) cycle();
        abort = 1'b1;
        accept(2);
        abort = 1'b0;
        check("t4_accept", busy, 1);
        wait_done(32'h0, "t4_latency", 4);
        check("t4_acc", acc, -12);
        handshake();

        // Longest job the counter width allows.
        accept(255);
        wait_done(32'h0, "tmax_latency", 257);
        check("tmax_addr", rd_addr,    255);
        check("tmax_run",  run_cycles, 255);
        check("tmax_acc",  acc,        -1530);
        handshake();

        // Asynchronous reset mid-RUN.
        accept(8);
        repeat (2) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy",   busy,      0);
        check("t5_en",     pe_enable, 0);
        check("t5_rdy",    op_ready,  0);
        check("t5_clr",    pe_clear,  0);
        check("t5_rdaddr", rd_addr,   0);
        check("t5_resv",   res_valid, 0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // DONE holds against a new start and an idle downstream.
        accept(1);
        wait_done(32'h0, "t5_latency", 3);
        start = 1'b1;
        k_len = 8'd5;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t5_hold", res_valid, 1);
        end
        start = 1'b0;
        handshake();
        cycle();
        check("t5_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
